// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO push arbiter.
package fifo_arb_pkg;

  localparam int FIFO_ARB_CNTW = 32;
  localparam int NREQ          = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/fifo_push_arb_if.sv
// Producer request/data lanes plus the FIFO push side, as seen by the arbiter.
interface fifo_push_arb_if #(
  parameter int busw = 32,
  parameter int nreq = 4
);
  logic [nreq-1:0]      req;
  logic [nreq*busw-1:0] din;
  logic [nreq-1:0]      gnt;
  logic                 fifo_full;
  logic                 fifo_push;
  logic [busw-1:0]      fifo_datain;

  modport master (
    input  req, din, fifo_full,
    output gnt, fifo_push, fifo_datain
  );

  modport slave (
    output req, din, fifo_full,
    input  gnt, fifo_push, fifo_datain
  );
endinterface

// File: rtl/fifo_arb_rr_pick.sv
// Round-robin pick: first set req bit searching upward from ptr, wrapping at nreq-1.
module fifo_arb_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int nreq = NREQ,
  localparam int pw  = (nreq > 1) ? $clog2(nreq) : 1
) (
  input  logic [nreq-1:0] req,
  input  logic [pw-1:0]   ptr,
  output logic [pw-1:0]   winner,
  output logic            any
);

  logic [pw-1:0] idx;

  // Scan farthest-first so the nearest requester at or after ptr is written last.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int k = nreq - 1; k >= 0; k--) begin
      idx = pw'((int'(ptr) + k) % nreq);
      if (req[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_push_arb.sv
// Round-robin push arbiter feeding one FIFO through a one-entry stage, with flush/drain.
// Optional per-requester grant counters enabled by FIFO_ARB_STATS_EN.
//
// state | meaning
// RUN   | normal arbitration, grants allowed
// DRAIN | no grants, waiting for the staged word to leave
// DONE  | flush_done pulse, back to RUN next cycle
module fifo_push_arb
  import fifo_arb_pkg::*;
#(
  parameter int busw = 32,
  parameter int nreq = NREQ,
  localparam int pw  = (nreq > 1) ? $clog2(nreq) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  fifo_push_arb_if.master             bus,
  input  logic                        flush,
  output logic                        flush_done,
  output logic [nreq*FIFO_ARB_CNTW-1:0] gnt_cnt
);

  arb_state_t    state, state_nxt;
  logic          stg_vld;
  logic [busw-1:0] stg_data;
  logic [pw-1:0] ptr, winner;
  logic          any, load;

  fifo_arb_rr_pick #(.nreq(nreq)) u_pick (
    .req    (bus.req),
    .ptr    (ptr),
    .winner (winner),
    .any    (any)
  );

  assign bus.fifo_push   = stg_vld & ~bus.fifo_full;
  assign bus.fifo_datain = stg_data;

  always_comb begin
    state_nxt  = state;
    flush_done = 1'b0;
    load       = 1'b0;
    bus.gnt    = '0;
    case (state)
      RUN: begin
        if (flush) begin
          state_nxt = DRAIN;
        end else if ((!stg_vld || bus.fifo_push) && any) begin
          load         = 1'b1;
          bus.gnt[winner] = 1'b1;
        end
      end
      DRAIN: begin
        if (!stg_vld || bus.fifo_push) state_nxt = DONE;
      end
      DONE: begin
        flush_done = 1'b1;
        state_nxt  = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      stg_vld  <= 1'b0;
      stg_data <= '0;
      ptr      <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        stg_data <= bus.din[winner*busw +: busw];
        stg_vld  <= 1'b1;
        ptr      <= pw'((int'(winner) + 1) % nreq);
      end else if (bus.fifo_push) begin
        stg_vld <= 1'b0;
      end
    end
  end

`ifdef FIFO_ARB_STATS_EN
  // A grant is only issued to a requesting lane, so gnt[i] alone marks an accepted word.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_cnt <= '0;
    end else begin
      for (int i = 0; i < nreq; i++) begin
        if (bus.gnt[i])
          gnt_cnt[i*FIFO_ARB_CNTW +: FIFO_ARB_CNTW] <= gnt_cnt[i*FIFO_ARB_CNTW +: FIFO_ARB_CNTW] + 1'b1;
      end
    end
  end
`else
  assign gnt_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_push_arb.sv
// Directed bench for fifo_push_arb with a small FIFO model and grant-order scoreboard.
module tb_fifo_push_arb;
  import fifo_arb_pkg::*;

  localparam int BW = 32;
  localparam int NR = 4;

  logic clk = 1'b0;
  logic rst, flush, flush_done;
  logic [NR*32-1:0] gnt_cnt;
  int n_tests = 0;
  int n_fail  = 0;

  fifo_push_arb_if #(.busw(BW), .nreq(NR)) bus ();

  fifo_push_arb #(.busw(BW), .nreq(NR)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .flush      (flush),
    .flush_done (flush_done),
    .gnt_cnt    (gnt_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_din(input logic [31:0] base);
    for (int i = 0; i < NR; i++) bus.din[i*BW +: BW] = base + 32'(i);
  endtask

  // FIFO model: words pushed become visible after the edge; full at 32 entries.
  logic use_model = 1'b0;
  logic pop = 1'b0;
  logic [31:0] fq[$];
  logic [31:0] sb[$];
  int popped = 0;

  always begin : model
    logic p;
    logic [31:0] d;
    logic [NR-1:0] g, r;
    logic [NR*BW-1:0] dn;
    @(negedge clk);
    p = bus.fifo_push; d = bus.fifo_datain; g = bus.gnt; r = bus.req; dn = bus.din;
    @(posedge clk);
    #1;
    if (use_model) begin
      for (int i = 0; i < NR; i++)
        if (g[i] && r[i]) sb.push_back(dn[i*BW +: BW]);
      if (p) fq.push_back(d);
      if (pop && fq.size() > 0) begin
        popped++;
        if (sb.size() == 0) check("sb_extra_word", 64'(fq.pop_front()), 64'hDEAD);
        else check("sb_order", 64'(fq.pop_front()), 64'(sb.pop_front()));
      end
      bus.fifo_full = (fq.size() >= 32);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0;
    bus.req = '0; bus.din = '0; bus.fifo_full = 1'b0;
    tick(); tick();
    mid();
    check("rst_gnt", bus.gnt, 0);
    check("rst_push", bus.fifo_push, 0);
    check("rst_datain", bus.fifo_datain, 0);
    check("rst_done", flush_done, 0);
    check("rst_cnt", 64'(|gnt_cnt), 0);
    tick();

    // all requesting: 0,1,2,3,0,... with push from 2nd cycle
    rst = 1'b0; bus.req = 4'b1111; set_din(32'h100);
    for (int k = 0; k < 8; k++) begin
      mid();
      check("rr_gnt", bus.gnt, 64'(1) << (k % 4));
      check("rr_push", bus.fifo_push, 64'(k > 0));
      if (k > 0) check("rr_data", bus.fifo_datain, 64'(32'h100 + 32'((k - 1) % 4)));
      tick();
    end
    bus.req = '0;
    mid();
    check("tail_gnt", bus.gnt, 0);
    check("tail_push", bus.fifo_push, 1);
    check("tail_data", bus.fifo_datain, 32'h103);
    tick(); mid();
    check("empty_push", bus.fifo_push, 0);
    tick();

    // sparse requests, then single requester wrapping ptr back to 0
    bus.req = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      mid();
      check("sparse_gnt", bus.gnt, (k % 2 == 1) ? 4'b0100 : 4'b0001);
      tick();
    end
    bus.req = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      mid();
      check("single_gnt", bus.gnt, 4'b1000);
      tick();
    end
    bus.req = 4'b1111;
    mid();
    check("ptr_wrap", bus.gnt, 4'b0001);
    tick();
    bus.req = '0; tick(); tick();

    // back-pressure with staged word A5A5A5A5 (ptr is 1 here)
    set_din(32'h0); bus.din[31:0] = 32'hA5A5A5A5; bus.req = 4'b0001;
    mid();
    check("bp_load_gnt", bus.gnt, 4'b0001);
    tick();
    bus.fifo_full = 1'b1; bus.req = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      mid();
      check("bp_push", bus.fifo_push, 0);
      check("bp_gnt", bus.gnt, 0);
      check("bp_data", bus.fifo_datain, 32'hA5A5A5A5);
      tick();
    end
    bus.fifo_full = 1'b0;
    mid();
    check("rel_push", bus.fifo_push, 1);
    check("rel_gnt", bus.gnt, 4'b0010);
    check("rel_data", bus.fifo_datain, 32'hA5A5A5A5);
    tick(); mid();
    check("rel_next_data", bus.fifo_datain, 32'h1);
    bus.req = '0;
    tick(); tick();

    // fill the FIFO model to 32, stall, then drain and scoreboard
    fq.delete(); sb.delete(); popped = 0;
    use_model = 1'b1; bus.req = 4'b1111;
    for (int k = 0; k < 40; k++) begin
      set_din(32'hC000_0000 | 32'(k << 4));
      tick();
    end
    mid();
    check("fill_full", bus.fifo_full, 1);
    check("fill_gnt", bus.gnt, 0);
    check("fill_push", bus.fifo_push, 0);
    check("fill_depth", 64'(fq.size()), 32);
    check("fill_granted", 64'(sb.size()), 33);
    tick();
    bus.req = '0; pop = 1'b1;
    for (int k = 0; k < 40; k++) tick();
    check("drain_popped", 64'(popped), 33);
    check("drain_sb_left", 64'(sb.size()), 0);
    check("drain_fifo_left", 64'(fq.size()), 0);
    use_model = 1'b0; pop = 1'b0;
    tick();
    bus.fifo_full = 1'b0;
    tick();

    // flush with the stage full (ptr is 1 after last grant cycle)
    set_din(32'h55); bus.req = 4'b0001;
    tick();
    bus.req = 4'b1111; flush = 1'b1;
    mid();
    check("fl_c0_gnt", bus.gnt, 0);
    check("fl_c0_push", bus.fifo_push, 1);
    check("fl_c0_done", flush_done, 0);
    tick();
    flush = 1'b0;
    mid();
    check("fl_c1_gnt", bus.gnt, 0);
    check("fl_c1_push", bus.fifo_push, 0);
    check("fl_c1_done", flush_done, 0);
    tick(); mid();
    check("fl_c2_done", flush_done, 1);
    check("fl_c2_gnt", bus.gnt, 0);
    tick(); mid();
    check("fl_c3_done", flush_done, 0);
    check("fl_c3_gnt", bus.gnt, 4'b0010);
    tick();
    bus.req = '0; tick(); tick();

    // flush held with empty stage: done every 3rd cycle
    flush = 1'b1;
    for (int k = 0; k < 7; k++) begin
      mid();
      check("fl_hold_done", flush_done, 64'(k % 3 == 2));
      tick();
    end
    flush = 1'b0;
    tick(); tick(); tick();

    // grant counters and mid-stream reset
    rst = 1'b1; tick(); rst = 1'b0;
    bus.req = 4'b0010;
    for (int k = 0; k < 10; k++) begin
      mid();
      if (k == 9) check("cnt_gnt", bus.gnt, 4'b0010);
      tick();
    end
    bus.req = '0; tick(); tick(); mid();
`ifdef FIFO_ARB_STATS_EN
    check("cnt1", gnt_cnt[32 +: 32], 10);
    check("cnt0", gnt_cnt[0 +: 32], 0);
    check("cnt2", gnt_cnt[64 +: 32], 0);
    check("cnt3", gnt_cnt[96 +: 32], 0);
`else
    check("cnt_off", 64'(|gnt_cnt), 0);
`endif
    tick();
    bus.req = 4'b1111; tick(); tick(); mid();
`ifdef FIFO_ARB_STATS_EN
    check("cnt2_pre_rst", gnt_cnt[64 +: 32], 1);
`endif
    check("pre_rst_push", bus.fifo_push, 1);
    tick();
    rst = 1'b1; bus.req = '0;
    tick();
    rst = 1'b0;
    mid();
    check("mid_rst_push", bus.fifo_push, 0);
    check("mid_rst_cnt", 64'(|gnt_cnt), 0);
    tick(); mid();
    check("post_rst_push", bus.fifo_push, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
